// File: rtl/joy_serial_reader.sv
// Active master for a 74HC165-style joystick chain. It drives the load and shift
// clock, shifts in NBITS bits per frame and publishes two active-high button bytes.
module joy_serial_reader #(
  parameter int CLK_DIV    = 16,
  parameter int NBITS      = 16,
  parameter int LOAD_TICKS = 2,
  parameter int GAP_TICKS  = 64
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       en,
  input  logic       joy_data,
  output logic       joy_clk,
  output logic       joy_load_n,
  output logic [7:0] joy1,
  output logic [7:0] joy2,
  output logic       frame_valid
);

  localparam int PW = $clog2(CLK_DIV);
  localparam int BW = $clog2(NBITS + 1);
  localparam int TW = $clog2(GAP_TICKS + LOAD_TICKS + 1);

  typedef enum logic [2:0] {
    S_GAP,
    S_LOAD,
    S_SAMPLE,
    S_HIGH,
    S_DONE
  } state_t;

  state_t           state, state_n;
  logic [PW-1:0]    presc;
  logic             tick;
  logic             sync_meta, sync_data;
  logic [TW-1:0]    tick_cnt, tick_cnt_n;
  logic [BW-1:0]    bit_cnt, bit_cnt_n;
  logic [NBITS-1:0] sr, sr_n;
  logic             frame_end;

  assign tick = (presc == PW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  presc <= '0;
    else if (tick) presc <= '0;
    else           presc <= presc + 1'b1;
  end

  // joy_data is asynchronous to clk; idle level (not pressed) is 1.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b1;
      sync_data <= 1'b1;
    end else begin
      sync_meta <= joy_data;
      sync_data <= sync_meta;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_cnt_n  = bit_cnt;
    sr_n       = sr;
    frame_end  = 1'b0;
    case (state)
      S_GAP: begin
        // With en low the counter saturates so a re-enable starts on the next tick.
        if (tick) begin
          if (en && tick_cnt >= TW'(GAP_TICKS - 1)) begin
            state_n    = S_LOAD;
            tick_cnt_n = '0;
          end else if (tick_cnt < TW'(GAP_TICKS)) begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (tick) begin
          if (tick_cnt >= TW'(LOAD_TICKS - 1)) begin
            state_n    = S_SAMPLE;
            tick_cnt_n = '0;
            bit_cnt_n  = '0;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      S_SAMPLE: begin
        if (tick) begin
          sr_n      = {sr[NBITS-2:0], ~sync_data};
          bit_cnt_n = bit_cnt + 1'b1;
          state_n   = S_HIGH;
        end
      end
      S_HIGH: begin
        if (tick) begin
          if (bit_cnt == BW'(NBITS)) begin
            state_n   = S_DONE;
            frame_end = 1'b1;
          end else begin
            state_n = S_SAMPLE;
          end
        end
      end
      S_DONE: begin
        state_n    = S_GAP;
        tick_cnt_n = '0;
      end
      default: state_n = S_GAP;
    endcase
  end

  // Pin drivers are registered from the next state so they never glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_GAP;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      sr          <= '0;
      joy_clk     <= 1'b0;
      joy_load_n  <= 1'b1;
      joy1        <= '0;
      joy2        <= '0;
      frame_valid <= 1'b0;
    end else begin
      state       <= state_n;
      tick_cnt    <= tick_cnt_n;
      bit_cnt     <= bit_cnt_n;
      sr          <= sr_n;
      joy_clk     <= (state_n == S_HIGH);
      joy_load_n  <= (state_n != S_LOAD);
      frame_valid <= frame_end;
      if (frame_end) begin
        joy1 <= sr[NBITS-1 -: 8];
        joy2 <= sr[NBITS-9 -: 8];
      end
    end
  end

endmodule
